multicycle_addsub: RTL and testbench
====================================

Name: multicycle_addsub

Overview:
- Parametrised successor to the combinational n-bit ripple-carry adder in the ALU.
- Adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, so wide operands don't need a full-width carry chain in one cycle.
- Supports ADD/SUB/ADC/SBC and produces NZCV flags.
- Driven by the ALU control path through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK (CHUNK = WIDTH gives single-cycle operation).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block can accept (see Behaviour).
- op  input  2  operation: 00 ADD a+b, 01 SUB a+~b+1, 10 ADC a+b+cin, 11 SBC a+~b+cin.
- cin  input  1  carry input; used by ADC/SBC only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when result/flags become valid.
- result  output  WIDTH  sum/difference, held until the next accepted start.
- flags  output  4  {N,Z,C,V}, held with result.

Behaviour:
- Decided interface rule: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: result=0, flags=0, busy=0, done=0, state IDLE, chunk index 0, internal carry 0.
- States:
  - IDLE -> CALC on start=1.
  - CALC -> CALC while idx < NCHUNK-1.
  - CALC -> DONE at the edge completing chunk NCHUNK-1.
  - DONE -> CALC if start=1, else DONE -> IDLE.
- Accept rule: start is accepted in IDLE or DONE.
  - On acceptance, a, b, op and cin are latched (b inverted for SUB/SBC).
  - Initial carry is 0 for ADD, 1 for SUB, cin for ADC/SBC.
  - idx is cleared to 0 and busy goes to 1 on the next cycle.
- start while busy: ignored; latched operands are unchanged.
- Inputs only need to be valid on the accepting edge.
- Each CALC cycle computes one slice: slice[idx] = a_slice + b_slice + carry. The carry-out is registered into the next slice; idx increments.
  - Slices proceed LSB-first.
- After the final slice:
  - C = carry out of bit WIDTH-1. For SUB/SBC, C=1 means no borrow.
  - V = (a[MSB]==b_eff[MSB]) && (result[MSB]!=a[MSB]), where b_eff is the post-inversion operand.
  - N = result[MSB].
  - Z = (result == 0).
- Latency: start accepted at edge k -> done=1 and result/flags valid in the cycle after edge k+NCHUNK.
  - busy is high for exactly NCHUNK cycles.
  - done is high for exactly 1 cycle.
- Visibility: result and flags update only when entering DONE; intermediate slices are never visible on result.
  - Previous values hold during CALC.
- Back-to-back: start in the DONE cycle begins the next operation with no idle gap. done still pulses for the completed operation.
- Reset mid-operation: all outputs return to reset values immediately, the operation is aborted, and done never pulses for it.
- CHUNK = WIDTH: NCHUNK=1; busy is high 1 cycle, and done follows in the next.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001 -> after 4 busy cycles: done pulse, result=0x80000000, NZCV=1001.
- SUB a=5, b=5 -> result=0x00000000, NZCV=0110. SUB a=0, b=1 -> result=0xFFFFFFFF, NZCV=1000.
- ADC a=0xFFFFFFFF, b=0, cin=1 -> result=0x00000000, NZCV=0110. The carry must ripple across all 4 slices.
- SBC a=0x80000000, b=0x00000001, cin=1 -> result=0x7FFFFFFF, NZCV=0011.
- Handshake:
  - Start ADD 1+2, then assert start with 9+9 during busy -> result=3, and the second request is ignored.
  - Then start 4+4 in the DONE cycle -> busy next cycle, done again 4 cycles later with result=8.
- Reset and single-cycle configuration:
  - Assert rst_n=0 during the 2nd CALC cycle -> busy/done/result/flags=0 immediately, no done pulse after release.
  - Repeat ADD 0xFFFFFFFF+1 with WIDTH=32, CHUNK=32 -> busy 1 cycle, result=0, NZCV=0110.

Source files
------------

// File: rtl/multicycle_addsub.sv
// Multi-cycle ADD/SUB/ADC/SBC with NZCV flags, CHUNK bits per clock, LSB slice first.
// Latency: done pulses NCHUNK+1 cycles after start; start is ignored while busy.
module multicycle_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sl_sum;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        a_sl     = a_r[idx*CHUNK +: CHUNK];
        b_sl     = b_r[idx*CHUNK +: CHUNK];
        sl_sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
        acc_next = acc;
        acc_next[idx*CHUNK +: CHUNK] = sl_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= 4'b0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // op[0] selects subtraction (operand inversion), op[1] selects carry-in use
                        a_r   <= a;
                        b_r   <= op[0] ? ~b : b;
                        carry <= op[1] ? cin : op[0];
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    carry <= sl_sum[CHUNK];
                    if (idx == IDX_LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next;
                        flags  <= {acc_next[WIDTH-1],
                                   (acc_next == '0),
                                   sl_sum[CHUNK],
                                   (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                   (acc_next[WIDTH-1] != a_r[WIDTH-1])};
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed bench for multicycle_addsub: 4-slice instance plus a single-cycle (CHUNK=WIDTH) instance.
module tb_multicycle_addsub;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start1;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy,  done;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy1, done1;
    logic [31:0] result1;
    logic [3:0]  flags1;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBC = 2'b11;

    multicycle_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    multicycle_addsub #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .cin(cin), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(result1), .flags(flags1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic c);
        @(negedge clk);
        op = o; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = ~c;
    endtask

    task automatic wait_done(output int nbusy, output logic seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic c,
                          input logic [31:0] exp_res, input logic [3:0] exp_f);
        int   nb;
        logic seen;
        start_op(o, x, y, c);
        wait_done(nb, seen);
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_busycyc"}, nb, 32'd4);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_nzcv"}, 32'(flags), 32'(exp_f));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   nb;
        logic seen;
        int   ndone;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; op = ADD; cin = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", result,      32'd0);
        chk("rst_flags",  32'(flags),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf",  ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001);
        run_op("sub_eq",   SUB, 32'd5,         32'd5,         1'b0, 32'h0000_0000, 4'b0110);
        run_op("sub_brw",  SUB, 32'd0,         32'd1,         1'b1, 32'hFFFF_FFFF, 4'b1000);
        run_op("adc_rip",  ADC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110);
        run_op("sbc_ovf",  SBC, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0011);

        // start during busy is ignored; result holds the previous value through CALC
        start_op(ADD, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        chk("hold_res_calc", result, 32'h7FFF_FFFF);
        op = ADD; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_busy", 32'(busy), 32'd1);
        wait_done(nb, seen);
        chk("ign_done", 32'(seen), 32'd1);
        chk("ign_res",  result,    32'd3);

        // back-to-back start issued in the DONE cycle
        op = ADD; a = 32'd4; b = 32'd4; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done", 32'(done), 32'd0);
        wait_done(nb, seen);
        chk("b2b_seen",    32'(seen), 32'd1);
        chk("b2b_busycyc", nb,        32'd4);
        chk("b2b_res",     result,    32'd8);
        chk("b2b_nzcv",    32'(flags), 32'd0);

        // reset asserted in the second CALC cycle
        start_op(SUB, 32'd3, 32'd7, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_busy",   32'(busy),  32'd0);
        chk("mrst_done",   32'(done),  32'd0);
        chk("mrst_result", result,     32'd0);
        chk("mrst_flags",  32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mrst_no_done", ndone, 32'd0);

        // single-cycle instance
        @(negedge clk);
        op = ADD; a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        chk("sc_busy", 32'(busy1), 32'd1);
        chk("sc_done", 32'(done1), 32'd0);
        @(negedge clk);
        chk("sc_done_pulse", 32'(done1),  32'd1);
        chk("sc_busy_low",   32'(busy1),  32'd0);
        chk("sc_res",        result1,     32'd0);
        chk("sc_nzcv",       32'(flags1), 32'(4'b0110));
        @(negedge clk);
        chk("sc_done_1cyc",  32'(done1),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
